// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The timeout pulse exists only when ARB_TIMEOUT_EN is defined.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             release_i;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic             busy;
`ifdef ARB_TIMEOUT_EN
  logic             timeout;
`endif

`ifdef ARB_TIMEOUT_EN
  modport master (output req, release_i, input grant, grant_valid, busy, timeout);
  modport slave  (input req, release_i, output grant, grant_valid, busy, timeout);
`else
  modport master (output req, release_i, input grant, grant_valid, busy);
  modport slave  (input req, release_i, output grant, grant_valid, busy);
`endif

endinterface

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin pick: rotate so ptr sits at bit 0, take the
// lowest set bit, rotate back. Masked bits are never eligible.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   sel;
  logic [2*N_REQ-1:0] dbl_r;
  logic [2*N_REQ-1:0] dbl_l;

  assign elig  = req & ~mask;
  assign any   = |elig;

  // Rotate right by ptr: rot[i] = elig[(i+ptr) mod N].
  assign dbl_r = {elig, elig} >> ptr;
  assign rot   = dbl_r[N_REQ-1:0];

  // Isolate the lowest set bit, i.e. the first requester in search order.
  assign sel   = rot & (~rot + ONE);

  // Rotate back left by ptr.
  assign dbl_l = {sel, sel} << ptr;
  assign win   = dbl_l[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold-until-release grants.
// Optional forced release after HOLD_MAX cycles: define ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, grant = 0
// GRANT | one owner, grant one-hot, held until release (or timeout)
module rr_arbiter4 #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 16
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter4_if.slave  bus
);
  import arb_pkg::*;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  if (N_REQ != 4 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_param
    $error("rr_arbiter4: N_REQ must be 4 and HOLD_MAX in 2..255");
  end

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             grant_valid_q;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  logic [N_REQ-1:0] win;
  logic             any;
  logic             force_rel;
  logic             rel;

  assign owner = onehot_idx(grant_q);

  // During a grant the search starts after the owner and excludes it, so the
  // releasing owner can never win on its own release cycle.
  assign pick_ptr  = (state_q == GRANT) ? owner + PTR_ONE : ptr_q;
  assign pick_mask = (state_q == GRANT) ? grant_q : '0;

  rr_pick u_pick (
    .req  (bus.req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .win  (win),
    .any  (any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_q, hold_d;
  logic       timeout_q;

  assign force_rel = (state_q == GRANT) && (hold_q == HOLD_LAST);

  // Tenure counter restarts on every new grant, including hand-offs.
  always_comb begin
    hold_d = hold_q;
    if (state_d == GRANT && (state_q == IDLE || rel)) hold_d = '0;
    else if (state_q == GRANT)                         hold_d = hold_q + 8'd1;
  end

  // Counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= force_rel;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_rel = 1'b0;
`endif

  assign rel = bus.release_i | force_rel;

  // Next-state, pointer rotation and next grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          grant_d = win;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = pick_ptr;
          if (any) begin
            grant_d = win;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= |grant_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.busy        = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4. Each scenario is a table of
// per-cycle stimulus with the grant required in the following cycle.
module tb_rr_arbiter4;
  import arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 16;
`endif

  typedef struct packed {
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] g;
    logic       to;
  } step_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  step_t exp_q[$];
  step_t tbl[$];

  always #5 clk = ~clk;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.N_REQ(4), .HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic step_t mk(input logic r, input logic [3:0] rq, input logic rl,
                               input logic [3:0] g, input logic to);
    step_t s;
    s.rst_n = r; s.req = rq; s.rel = rl; s.g = g; s.to = to;
    return s;
  endfunction

  // Every cycle: grant must be one-hot or zero and grant_valid must track it.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if ($isunknown(bus.grant) || $countones(bus.grant) > 1 || bus.grant_valid !== (|bus.grant)) begin
        n_bad++;
        $display("FAIL onehot t=%0t: grant=%b grant_valid=%b, required one-hot/zero with valid=|grant",
                 $time, bus.grant, bus.grant_valid);
      end
    end
  end

  task automatic test_reset();
    step_t e;
    tbl = {};
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; bus.req = tbl[i].req; bus.release_i = tbl[i].rel;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      mon_en = 1'b1;
      n_cmp++;
      if (bus.grant !== e.g || bus.busy !== (|e.g)) begin
        n_bad++;
        $display("FAIL reset row %0d: grant=%b busy=%b, required grant=%b busy=%b", i, bus.grant, bus.busy, e.g, |e.g);
      end
`ifdef ARB_TIMEOUT_EN
      n_cmp++;
      if (bus.timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_timeout row %0d: timeout=%b, required 0", i, bus.timeout);
      end
`endif
    end
  endtask

  task automatic test_basic();
    step_t e;
    tbl = {};
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0101, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0101, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0101, 1, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0101, 0, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0101, 1, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; bus.req = tbl[i].req; bus.release_i = tbl[i].rel;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.grant !== e.g || bus.busy !== (|e.g)) begin
        n_bad++;
        $display("FAIL basic row %0d: grant=%b busy=%b, required grant=%b busy=%b", i, bus.grant, bus.busy, e.g, |e.g);
      end
    end
  endtask

  task automatic test_rotate();
    step_t e;
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    tbl = {};
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(1, 4'b1111, (k % 3) == 2, order[(k + 1) / 3], 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; bus.req = tbl[i].req; bus.release_i = tbl[i].rel;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.grant !== e.g || bus.busy !== (|e.g)) begin
        n_bad++;
        $display("FAIL rotate row %0d: grant=%b busy=%b, required grant=%b busy=%b", i, bus.grant, bus.busy, e.g, |e.g);
      end
    end
  endtask

  task automatic test_hold();
    step_t e;
    tbl = {};
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b1011, 0, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; bus.req = tbl[i].req; bus.release_i = tbl[i].rel;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.grant !== e.g || bus.busy !== (|e.g)) begin
        n_bad++;
        $display("FAIL hold row %0d: grant=%b busy=%b, required grant=%b busy=%b", i, bus.grant, bus.busy, e.g, |e.g);
      end
    end
  endtask

  task automatic test_single();
    step_t e;
    tbl = {};
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0010, 0, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0010, 1, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0010, 1, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0010, 0, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0010, 1, 4'b0000, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; bus.req = tbl[i].req; bus.release_i = tbl[i].rel;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.grant !== e.g || bus.busy !== (|e.g)) begin
        n_bad++;
        $display("FAIL single row %0d: grant=%b busy=%b, required grant=%b busy=%b", i, bus.grant, bus.busy, e.g, |e.g);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t e;
    tbl = {};
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0001, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; bus.req = tbl[i].req; bus.release_i = tbl[i].rel;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.grant !== e.g || bus.busy !== (|e.g)) begin
        n_bad++;
        $display("FAIL reset_mid row %0d: grant=%b busy=%b, required grant=%b busy=%b", i, bus.grant, bus.busy, e.g, |e.g);
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    step_t e;
    tbl = {};
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 4'b0011, 0, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 4'b0010, 1));
    tbl.push_back(mk(1, 4'b0011, 0, 4'b0010, 0));
    tbl.push_back(mk(1, 4'b0011, 1, 4'b0001, 0));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; bus.req = tbl[i].req; bus.release_i = tbl[i].rel;
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.grant !== e.g || bus.timeout !== e.to) begin
        n_bad++;
        $display("FAIL timeout row %0d: grant=%b timeout=%b, required grant=%b timeout=%b", i, bus.grant, bus.timeout, e.g, e.to);
      end
    end
  endtask
`endif

  initial begin
    bus.req = 4'b0000;
    bus.release_i = 1'b0;
    test_reset();
    test_basic();
    test_rotate();
    test_hold();
    test_single();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    @(negedge clk);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that produces the one-hot request vector consumed by the downstream 4-to-2 encoder. Each requester raises a level request. The arbiter grants exactly one requester and holds that grant until the owner releases it, then rotates priority. The registered grant vector is guaranteed one-hot or zero, so the encoder's single-input assumption always holds and its `valid` output equals `grant_valid`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Fixed at 4 to match the encoder width; other values are unsupported.
- `HOLD_MAX`, default 16: maximum grant tenure in cycles, range 2..255. Used only when `ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  single clock; all logic is on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `req`  input  4  level requests; bit i belongs to requester i.
- `release_i`  input  1  pulse from the current owner to end its grant.
- `grant`  output  4  registered grant vector, one-hot or zero; feeds encoder `in`.
- `grant_valid`  output  1  registered; equals `|grant`.
- `busy`  output  1  high while in the GRANT state.
- `timeout`  output  1  one-cycle pulse on forced release. Present only with `ARB_TIMEOUT_EN`.

## Operation
- Two states:
  - IDLE: `grant` = 0.
  - GRANT: `grant` is one-hot.
- Priority pointer `ptr[1:0]` holds the highest-priority index. The search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- IDLE → GRANT when `req` ≠ 0. The winner is the first set bit in search order.
- GRANT → hold: the grant stays fixed while `release_i` = 0.
  - It stays fixed even if the owner drops its `req`.
  - `req` changes from other requesters have no effect during the grant.
- GRANT with `release_i` = 1:
  - `ptr` ← owner+1 mod 4.
  - If `req` with the owner bit masked is nonzero, grant the next winner in the following cycle, searching from the new `ptr`, with no idle bubble.
  - Otherwise go to IDLE.
- The releasing owner is never re-granted on the release cycle, even if its `req` is still high. It is eligible again once it is next in rotation.
- `release_i` in IDLE is ignored.
- Simultaneous `release_i` and forced timeout count as one release, and `timeout` still pulses.
- Reset values: state IDLE, `ptr` 0, `grant` 0, `grant_valid` 0, `busy` 0, `timeout` 0, hold counter 0.
- Reset asserted mid-grant clears everything at the next edge, regardless of `req` or `release_i`.

## Timing
- Request latency: `req` sampled at edge t appears as `grant` after edge t. `grant` is visible during cycle t+1.
- Release latency: `release_i` sampled at edge t changes `grant` after edge t, either to the next owner or to 0.
- `grant`, `grant_valid` and `busy` are all registered outputs with no combinational path from inputs.
- Downstream encoder output is combinational from `grant`, so the encoded code is valid in the same cycle as `grant`.
- `timeout` is registered and asserts in the same cycle that `grant` changes due to the forced release.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on every new grant and increments each GRANT cycle.
  - When the counter reaches `HOLD_MAX`-1 without `release_i`, the arbiter performs an internal release with the same rotation rules and pulses `timeout`.
- `ARB_TIMEOUT_EN` undefined:
  - No counter and no `timeout` port.
  - Grants are held indefinitely until `release_i`.

## Structure
- Shared package `arb_pkg` contains:
  - `N_REQ` as a localparam.
  - State enum `arb_state_t` with values IDLE and GRANT.
  - Width constant for `ptr`.
- Sub-module `rr_pick`: combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`, `mask[3:0]`.
  - Outputs: one-hot `win[3:0]` and `any`.
  - It implements rotate, priority-select and rotate-back. It is instantiated once.

## Test plan
- After reset, `req`=4'b0101 at edge 1 → `grant`=4'b0001 in cycle 2. `release_i` at edge 3 → `grant`=4'b0100 in cycle 4, `ptr`=1 before that grant and 3 after its release.
- `req`=4'b1111 held, `release_i` pulsed every 3 cycles → grants cycle 0001, 0010, 0100, 1000, 0001 with no zero cycles between them.
- Owner 2 granted, then `req`=4'b0000 with no release → `grant` stays 4'b0100. `release_i` → `grant`=0 and `busy`=0 the next cycle.
- Only `req`[1] high with repeated releases → grant alternates between 4'b0010 and 0, never 4'b0010 on consecutive cycles. `release_i` in IDLE produces no change.
- `rst_n`=0 during a grant with `req`=4'b1111 → the next cycle shows `grant`=0 and `busy`=0. After reset is released, the first grant is 4'b0001.
- With `ARB_TIMEOUT_EN`, `HOLD_MAX`=4, `req`=4'b0011, no release → `grant`=0001 for 4 cycles, then 0010 with `timeout`=1 for one cycle. Bench checks `grant` is one-hot or zero every cycle in all tests.
